// File: rtl/add_sub_pkg.sv
// ============================================================================
// Module  : add_sub_pkg
// Brief   : Shared helpers and constants for the pipelined add/subtract unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package add_sub_pkg;

    // Subtract runs as A + ~B + ~borrow, so the slice-0 carry flips with SUB.
    localparam logic SUB_CARRY_INV = 1'b1;

    function automatic int calc_stages(input int width, input int seg);
        return (seg >= 1) ? (width / seg) : 1;
    endfunction

    function automatic bit params_ok(input int width, input int seg);
        return (seg >= 1) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/add_sub_slice.sv
// ============================================================================
// Module  : add_sub_slice
// Brief   : SEG-bit ripple carry-chain slice with registered sum and carry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_sub_slice #(
    parameter int SEG = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           ce_i,
    input  logic           sub_i,
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           cin_i,
    output logic [SEG-1:0] sum_o,
    output logic           cout_o
);

    logic [SEG-1:0] w_b;
    logic [SEG-1:0] w_p;
    logic [SEG-1:0] w_g;
    logic [SEG:0]   w_c;
    logic [SEG-1:0] sum_d;
    logic           cout_d;
    logic [SEG-1:0] sum_q;
    logic           cout_q;

    // Propagate/generate split mirrors a LUT feeding a dedicated carry mux.
    always_comb begin
        w_b    = b_i ^ {SEG{sub_i}};
        w_p    = a_i ^ w_b;
        w_g    = a_i;
        w_c    = '0;
        w_c[0] = cin_i;
        sum_d  = '0;
        for (int i = 0; i < SEG; i++) begin
            sum_d[i]  = w_p[i] ^ w_c[i];
            w_c[i+1]  = w_p[i] ? w_c[i] : w_g[i];
        end
        cout_d = w_c[SEG];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (ce_i) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

`default_nettype wire

// File: rtl/add_sub_pipe.sv
// ============================================================================
// Module  : add_sub_pipe
// Brief   : WIDTH-bit add/subtract split into SEG-bit carry slices with one
//           register stage per slice; operands skewed in, sums deskewed out.
//           Optional signed-overflow output V under ADD_SUB_PIPE_OVERFLOW_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             CE,
    input  logic             VALID_IN,
    input  logic             SUB,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             CIN,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             VALID_OUT
`ifdef ADD_SUB_PIPE_OVERFLOW_EN
    ,
    output logic             V
`endif
);

    localparam int STAGES = calc_stages(WIDTH, SEG);

    if (!params_ok(WIDTH, SEG)) begin : g_bad_params
        $error("add_sub_pipe: WIDTH must be a non-zero multiple of SEG");
    end

    logic [SEG-1:0]    w_a_sl    [STAGES];
    logic [SEG-1:0]    w_b_sl    [STAGES];
    logic              w_sub_sl  [STAGES];
    logic              w_cin_sl  [STAGES];
    logic [SEG-1:0]    w_sum_sl  [STAGES];
    logic              w_cout_sl [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        if (k == 0) begin : g_head
            assign w_a_sl[k]   = I0[SEG-1:0];
            assign w_b_sl[k]   = I1[SEG-1:0];
            assign w_sub_sl[k] = SUB;
            assign w_cin_sl[k] = CIN ^ (SUB & SUB_CARRY_INV);
        end else begin : g_skew
            // Slice k sees its operands k cycles late, in step with the carry.
            logic [SEG-1:0] a_skew_q [k];
            logic [SEG-1:0] b_skew_q [k];
            logic [k-1:0]   sub_skew_q;

            always_ff @(posedge CLK or posedge ASYNCRESET) begin
                if (ASYNCRESET) begin
                    for (int i = 0; i < k; i++) begin
                        a_skew_q[i] <= '0;
                        b_skew_q[i] <= '0;
                    end
                    sub_skew_q <= '0;
                end else if (CE) begin
                    a_skew_q[0]   <= I0[k*SEG +: SEG];
                    b_skew_q[0]   <= I1[k*SEG +: SEG];
                    sub_skew_q[0] <= SUB;
                    for (int i = 1; i < k; i++) begin
                        a_skew_q[i]   <= a_skew_q[i-1];
                        b_skew_q[i]   <= b_skew_q[i-1];
                        sub_skew_q[i] <= sub_skew_q[i-1];
                    end
                end
            end

            assign w_a_sl[k]   = a_skew_q[k-1];
            assign w_b_sl[k]   = b_skew_q[k-1];
            assign w_sub_sl[k] = sub_skew_q[k-1];
            assign w_cin_sl[k] = w_cout_sl[k-1];
        end

        add_sub_slice #(
            .SEG (SEG)
        ) u_slice (
            .clk_i  (CLK),
            .rst_i  (ASYNCRESET),
            .ce_i   (CE),
            .sub_i  (w_sub_sl[k]),
            .a_i    (w_a_sl[k]),
            .b_i    (w_b_sl[k]),
            .cin_i  (w_cin_sl[k]),
            .sum_o  (w_sum_sl[k]),
            .cout_o (w_cout_sl[k])
        );

        if (k == STAGES - 1) begin : g_direct
            assign O[k*SEG +: SEG] = w_sum_sl[k];
        end else begin : g_deskew
            localparam int DLY = STAGES - 1 - k;
            logic [SEG-1:0] dly_q [DLY];

            always_ff @(posedge CLK or posedge ASYNCRESET) begin
                if (ASYNCRESET) begin
                    for (int i = 0; i < DLY; i++) begin
                        dly_q[i] <= '0;
                    end
                end else if (CE) begin
                    dly_q[0] <= w_sum_sl[k];
                    for (int i = 1; i < DLY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign O[k*SEG +: SEG] = dly_q[DLY-1];
        end
    end

    always_comb begin
        valid_d    = '0;
        valid_d[0] = VALID_IN;
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            valid_q <= '0;
        end else if (CE) begin
            valid_q <= valid_d;
        end
    end

    assign VALID_OUT = valid_q[STAGES-1];
    assign COUT      = w_cout_sl[STAGES-1];

`ifdef ADD_SUB_PIPE_OVERFLOW_EN
    // Overflow when both effective operand signs agree but the result sign differs.
    logic sign_a_q;
    logic sign_b_q;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else if (CE) begin
            sign_a_q <= w_a_sl[STAGES-1][SEG-1];
            sign_b_q <= w_b_sl[STAGES-1][SEG-1] ^ w_sub_sl[STAGES-1];
        end
    end

    assign V = (sign_a_q == sign_b_q) && (O[WIDTH-1] != sign_a_q);
`endif

endmodule

`default_nettype wire

// File: tb/tb_add_sub_pipe.sv
// ============================================================================
// Module  : tb_add_sub_pipe
// Brief   : Self-checking bench: directed literal cases plus random traffic
//           compared against an arithmetic model on every enabled cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_sub_pipe;

    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int STAGES = WIDTH / SEG;

    logic             CLK        = 1'b0;
    logic             ASYNCRESET = 1'b1;
    logic             CE         = 1'b0;
    logic             VALID_IN   = 1'b0;
    logic             SUB        = 1'b0;
    logic             CIN        = 1'b0;
    logic [WIDTH-1:0] I0         = '0;
    logic [WIDTH-1:0] I1         = '0;
    logic [WIDTH-1:0] O;
    logic             COUT;
    logic             VALID_OUT;
`ifdef ADD_SUB_PIPE_OVERFLOW_EN
    logic             V;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    add_sub_pipe #(
        .WIDTH (WIDTH),
        .SEG   (SEG)
    ) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .CE         (CE),
        .VALID_IN   (VALID_IN),
        .SUB        (SUB),
        .I0         (I0),
        .I1         (I1),
        .CIN        (CIN),
        .O          (O),
        .COUT       (COUT),
        .VALID_OUT  (VALID_OUT)
`ifdef ADD_SUB_PIPE_OVERFLOW_EN
        ,
        .V          (V)
`endif
    );

    typedef struct {
        bit               v;
        logic [WIDTH-1:0] o;
        bit               c;
        bit               ovf;
    } exp_t;

    exp_t hist[$];
    int   edges_since_rst = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: unsigned result/carry and signed range test.
    function automatic exp_t model(input bit v, input bit s, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input bit ci);
        exp_t   e;
        longint m    = longint'(1) << WIDTH;
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = a[WIDTH-1] ? ua - m : ua;
        longint sb   = b[WIDTH-1] ? ub - m : ub;
        longint full = s ? (ua - ub - longint'(ci)) : (ua + ub + longint'(ci));
        longint sres = s ? (sa - sb - longint'(ci)) : (sa + sb + longint'(ci));
        e.v   = v;
        e.o   = full[WIDTH-1:0];
        e.c   = s ? (full >= 0) : (full >= m);
        e.ovf = (sres >= (m / 2)) || (sres < -(m / 2));
        return e;
    endfunction

    always @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            hist.delete();
            edges_since_rst = 0;
        end else if (CE) begin
            hist.push_back(model(VALID_IN, SUB, I0, I1, CIN));
            if (hist.size() > STAGES) void'(hist.pop_front());
            edges_since_rst++;
        end
    end

    always @(negedge CLK) begin
        if (!ASYNCRESET) begin
            if (hist.size() == STAGES) begin
                chk("valid_out", 64'(VALID_OUT), 64'(hist[0].v));
                if (hist[0].v) begin
                    chk("o", 64'(O), 64'(hist[0].o));
                    chk("cout", 64'(COUT), 64'(hist[0].c));
`ifdef ADD_SUB_PIPE_OVERFLOW_EN
                    chk("v", 64'(V), 64'(hist[0].ovf));
`endif
                end
            end else begin
                chk("valid_out_fill", 64'(VALID_OUT), 64'd0);
                if (edges_since_rst == 0) begin
                    chk("o_after_reset", 64'(O), 64'd0);
                    chk("cout_after_reset", 64'(COUT), 64'd0);
                end
            end
        end
    end

    task automatic step(input bit ce, input bit v, input bit s, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit ci);
        CE = ce; VALID_IN = v; SUB = s; I0 = a; I1 = b; CIN = ci;
        @(negedge CLK);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic lit(input string name, input logic [WIDTH-1:0] eo, input bit ec);
        chk({name, "_valid"}, 64'(VALID_OUT), 64'd1);
        chk({name, "_o"}, 64'(O), 64'(eo));
        chk({name, "_cout"}, 64'(COUT), 64'(ec));
    endtask

    function automatic logic [WIDTH-1:0] pick();
        logic [WIDTH-1:0] corners [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
        if ($urandom_range(3) == 0) return corners[$urandom_range(3)];
        return WIDTH'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_o", 64'(O), 64'd0);
        chk("reset_cout", 64'(COUT), 64'd0);
        chk("reset_valid", 64'(VALID_OUT), 64'd0);
        ASYNCRESET = 1'b0;
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        // Wrap-around add with carry out, valid for exactly one cycle.
        step(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        repeat (3) idle();
        lit("wrap_add", 16'h0000, 1'b1);
        idle();
        chk("wrap_add_one_cycle", 64'(VALID_OUT), 64'd0);

        // Subtract with and without borrow-in.
        step(1'b1, 1'b1, 1'b1, 16'h0005, 16'h0007, 1'b0);
        step(1'b1, 1'b1, 1'b1, 16'h1234, 16'h0234, 1'b1);
        repeat (2) idle();
        lit("sub_borrow", 16'hFFFE, 1'b0);
        idle();
        lit("sub_cin", 16'h0FFF, 1'b1);

        // Back-to-back, alternating add/subtract.
        step(1'b1, 1'b1, 1'b0, 16'h00FF, 16'h0001, 1'b0);
        step(1'b1, 1'b1, 1'b1, 16'h1000, 16'h0001, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0);
        step(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1);
        lit("stream0", 16'h0100, 1'b0);
        idle();
        lit("stream1", 16'h0FFF, 1'b1);
        idle();
        lit("stream2", 16'h0000, 1'b1);
        idle();
        lit("stream3", 16'hFFFF, 1'b0);

        // Stall for three cycles with two operations in flight.
        step(1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0);
        step(1'b1, 1'b1, 1'b1, 16'h5000, 16'h1000, 1'b0);
        repeat (3) begin
            step(1'b0, 1'b1, 1'b1, 16'hABCD, 16'h1234, 1'b1);
            chk("stall_valid", 64'(VALID_OUT), 64'd0);
        end
        repeat (2) idle();
        lit("stall_a", 16'h3333, 1'b0);
        idle();
        lit("stall_b", 16'h4000, 1'b1);

        // Asynchronous reset while results are visible and three more in flight.
        step(1'b1, 1'b1, 1'b0, 16'h0101, 16'h0202, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0303, 16'h0404, 1'b0);
        step(1'b1, 1'b1, 1'b1, 16'h0909, 16'h0101, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h1010, 16'h2020, 1'b1);
        lit("pre_reset", 16'h0303, 1'b0);
        #2 ASYNCRESET = 1'b1;
        #1;
        chk("async_reset_o", 64'(O), 64'd0);
        chk("async_reset_valid", 64'(VALID_OUT), 64'd0);
        chk("async_reset_cout", 64'(COUT), 64'd0);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        step(1'b1, 1'b1, 1'b0, 16'h00AA, 16'h0055, 1'b0);
        repeat (2) begin
            idle();
            chk("post_reset_no_stale", 64'(VALID_OUT), 64'd0);
        end
        idle();
        lit("post_reset", 16'h00FF, 1'b0);

`ifdef ADD_SUB_PIPE_OVERFLOW_EN
        step(1'b1, 1'b1, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
        step(1'b1, 1'b1, 1'b1, 16'h8000, 16'h0001, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0004, 1'b0);
        idle();
        lit("ovf_add", 16'h8000, 1'b0);
        chk("ovf_add_v", 64'(V), 64'd1);
        idle();
        lit("ovf_sub", 16'h7FFF, 1'b1);
        chk("ovf_sub_v", 64'(V), 64'd1);
        idle();
        lit("no_ovf", 16'h0007, 1'b0);
        chk("no_ovf_v", 64'(V), 64'd0);
`endif

        // Random traffic with stalls and bubbles, checked by the model.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(9) != 0), ($urandom_range(3) != 0), 1'($urandom),
                 pick(), pick(), 1'($urandom));
        end
        repeat (STAGES + 2) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
